riscv_mem_arbiter: RTL and testbench
====================================

# riscv_mem_arbiter

Arbitrates the single memory port of the RISC-V core between the instruction-fetch requester and the data load/store requester. Sits between `riscv_core` and the unified instruction/data memory. Tracks outstanding requests in order so each memory response is routed back to its issuer. Supports an instruction-fetch flush that drops in-flight fetch responses after a taken branch or jump.

## Interface

Parameters:
- `WIDTH`, 32, address and data width; byte-enable width is `WIDTH/8`.
- `MAX_OUTSTANDING`, 4, maximum accepted-but-unanswered memory requests (≥2).
- `STARVE_LIMIT`, 8, consecutive lost cycles after which fetch overrides data priority (≥1).

Ports:
- `master_clk` in 1: the only clock; all state updates on the rising edge.
- `master_rst` in 1: reset, synchronous and active-high.
- `if_req_valid` in 1, `if_req_ready` out 1, `if_req_addr` in WIDTH: fetch request.
- `if_rsp_valid` out 1, `if_rsp_data` out WIDTH: fetch response.
- `if_flush` in 1: single-cycle pulse discarding all in-flight fetches.
- `dm_req_valid` in 1, `dm_req_ready` out 1, `dm_req_addr` in WIDTH, `dm_req_we` in 1, `dm_req_wdata` in WIDTH, `dm_req_be` in WIDTH/8: data request.
- `dm_rsp_valid` out 1, `dm_rsp_data` out WIDTH: data response; writes also get one.
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_req_addr`, `mem_req_we`, `mem_req_wdata`, `mem_req_be`: memory request, with the same widths as the dm side.
- `mem_rsp_valid` in 1, `mem_rsp_data` in WIDTH: in-order memory response, one per accepted request.
- `outstanding` out $clog2(MAX_OUTSTANDING+1): current tracked request count.
- `arb_err` out 1: sticky protocol-error flag.

## Operation

- Handshake: a transfer occurs when valid && ready on the same edge. Requesters hold valid and payload stable until accepted. `mem_req_valid` never depends on `mem_req_ready`.
- Slot available: `outstanding < MAX_OUTSTANDING`. There is no same-cycle pop bypass.
- Grant selection when a slot is available:
  - DM wins if `dm_req_valid` && `starve_cnt < STARVE_LIMIT`.
  - Otherwise IF wins if `if_req_valid` && !`if_flush`.
  - Otherwise DM wins if valid.
- `mem_req_*` carries the granted requester's payload. IF drives we=0 and be=all-ones.
- `mem_req_valid` = a grant exists.
- `if_req_ready` / `dm_req_ready` = (own grant) && `mem_req_ready`.
- `if_req_ready` is 0 whenever `if_flush`=1.
- Starvation counter `starve_cnt`:
  - +1 per cycle when `if_req_valid` && !`if_req_ready`, saturating at STARVE_LIMIT.
  - Cleared on an IF transfer or when `if_req_valid`=0.
- Tag FIFO (depth MAX_OUTSTANDING, entry {src, discard}):
  - Push on each memory-request transfer.
  - Pop on each `mem_rsp_valid`.
  - Push and pop may happen in the same cycle; `outstanding` is then unchanged.
- Response routing (combinational from the head entry):
  - `if_rsp_valid` = `mem_rsp_valid` && head.src==IF && !head.discard && !`if_flush`.
  - `dm_rsp_valid` = `mem_rsp_valid` && head.src==DM.
  - Both rsp_data outputs = `mem_rsp_data`.
- Flush: on the `if_flush` edge, every IF entry in the FIFO gets discard=1. A head IF response in the flush cycle is itself dropped. DM entries are unaffected.
- Error: `mem_rsp_valid` with an empty FIFO is ignored (no pop, no response) and sets `arb_err`. `arb_err` is cleared only by reset.

## Timing

- Request path: zero-cycle, combinational from valid to mem valid and from mem ready to requester ready.
- Response path: zero-cycle, combinational mem_rsp to if/dm rsp. No response backpressure.
- Reset (synchronous, sampled on the edge), after which:
  - FIFO is empty and `outstanding`=0.
  - `starve_cnt`=0 and `arb_err`=0.
  - All valid/ready outputs are 0 in the following cycle (the empty FIFO forces rsp valids to 0).
- Reset mid-operation: all tracked entries are lost. A memory response arriving after reset sets `arb_err`, and the bench accounts for this.
- Full (`outstanding`==MAX_OUTSTANDING): both readies and `mem_req_valid` are 0 until a pop has occurred on a prior edge.
- FIFO pointers wrap modulo MAX_OUTSTANDING. Count width holds MAX_OUTSTANDING exactly.

## Structure

- `riscv_pkg` holds:
  - `typedef enum logic {SRC_IF, SRC_DM} arb_src_t;`
  - `typedef struct packed {arb_src_t src; logic discard;} arb_tag_t;`
- Sub-module `riscv_tag_fifo`: parameterised in-order FIFO of `arb_tag_t`.
  - Provides push, pop, head, count, full and empty.
  - Provides a `mark_discard` input that sets discard on all valid SRC_IF entries.
- Top module holds the grant logic, the starvation counter, routing and `arb_err`.

## Test plan

- Both requesters valid every cycle, `mem_req_ready`=1, 1-cycle response memory:
  - DM granted for 8 cycles, then IF granted on cycle 9.
  - `starve_cnt` returns to 0 afterwards.
- `mem_rsp_valid` held 0, IF issuing 4 requests:
  - `outstanding`=4 and `if_req_ready`=0.
  - One response arrives → if_rsp_valid=1 with the data, `outstanding`=3, next fetch accepted.
- Interleaved issue IF@0x0, DM write@0x100, IF@0x4, then responses D0, D1, D2:
  - D0 on if_rsp, D1 on dm_rsp, D2 on if_rsp, in order.
- Three IF requests outstanding, `if_flush` pulse, then 3 responses:
  - No if_rsp_valid.
  - A new fetch issued after the flush returns normally.
- `mem_rsp_valid`=1 with empty FIFO:
  - `arb_err`=1, held until `master_rst`.
  - No rsp valid asserted.
- Assert `master_rst` with 2 outstanding:
  - Next cycle `outstanding`=0 and all valids 0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types for the instruction/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_DM = 1'b1
    } arb_src_t;

    typedef struct packed {
        arb_src_t src;
        logic     discard;
    } arb_tag_t;

endpackage
`default_nettype wire

// File: rtl/riscv_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : riscv_tag_fifo
// Description : In-order tag FIFO recording the issuer of each memory request.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_tag_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  arb_tag_t                   push_tag_i,
    input  logic                       pop_i,
    input  logic                       mark_discard_i,
    output arb_tag_t                   head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] C_LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    arb_tag_t        mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // Stale slots may be marked too; a push overwrites the whole entry.
            for (int i = 0; i < DEPTH; i++) begin
                if (mark_discard_i && (mem_q[i].src == SRC_IF)) begin
                    mem_q[i].discard <= 1'b1;
                end
            end
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_tag_i;
                wr_ptr_q        <= (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == C_DEPTH);
    assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_arbiter
// Description : Shares one memory port between fetch and load/store requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                                 master_clk,
    input  logic                                 master_rst,
    input  logic                                 if_req_valid,
    output logic                                 if_req_ready,
    input  logic [WIDTH-1:0]                     if_req_addr,
    output logic                                 if_rsp_valid,
    output logic [WIDTH-1:0]                     if_rsp_data,
    input  logic                                 if_flush,
    input  logic                                 dm_req_valid,
    output logic                                 dm_req_ready,
    input  logic [WIDTH-1:0]                     dm_req_addr,
    input  logic                                 dm_req_we,
    input  logic [WIDTH-1:0]                     dm_req_wdata,
    input  logic [WIDTH/8-1:0]                   dm_req_be,
    output logic                                 dm_rsp_valid,
    output logic [WIDTH-1:0]                     dm_rsp_data,
    output logic                                 mem_req_valid,
    input  logic                                 mem_req_ready,
    output logic [WIDTH-1:0]                     mem_req_addr,
    output logic                                 mem_req_we,
    output logic [WIDTH-1:0]                     mem_req_wdata,
    output logic [WIDTH/8-1:0]                   mem_req_be,
    input  logic                                 mem_rsp_valid,
    input  logic [WIDTH-1:0]                     mem_rsp_data,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 arb_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_LIMIT);

    logic          gnt_if;
    logic          gnt_dm;
    logic          push;
    logic          pop;
    logic          if_xfer;
    logic          fifo_full;
    logic          fifo_empty;
    arb_tag_t      push_tag;
    arb_tag_t      head;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          arb_err_q;

    // DM has priority until fetch has lost STARVE_LIMIT cycles in a row.
    always_comb begin
        gnt_if = 1'b0;
        gnt_dm = 1'b0;
        if (!fifo_full) begin
            if (dm_req_valid && (starve_q < C_STARVE_MAX)) begin
                gnt_dm = 1'b1;
            end else if (if_req_valid && !if_flush) begin
                gnt_if = 1'b1;
            end else if (dm_req_valid) begin
                gnt_dm = 1'b1;
            end
        end
    end

    assign mem_req_valid = gnt_if | gnt_dm;
    assign mem_req_addr  = gnt_if ? if_req_addr : dm_req_addr;
    assign mem_req_we    = gnt_dm & dm_req_we;
    assign mem_req_wdata = gnt_dm ? dm_req_wdata : '0;
    assign mem_req_be    = gnt_if ? '1 : dm_req_be;

    assign if_req_ready  = gnt_if & mem_req_ready;
    assign dm_req_ready  = gnt_dm & mem_req_ready;

    assign if_xfer = if_req_valid & if_req_ready;
    assign push    = mem_req_valid & mem_req_ready;
    assign pop     = mem_rsp_valid & !fifo_empty;

    always_comb begin
        push_tag.src     = gnt_if ? SRC_IF : SRC_DM;
        push_tag.discard = 1'b0;
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req_valid || if_xfer) begin
            starve_d = '0;
        end else if (starve_q < C_STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge master_clk) begin
        if (master_rst) begin
            starve_q  <= '0;
            arb_err_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            if (mem_rsp_valid && fifo_empty) begin
                arb_err_q <= 1'b1;
            end
        end
    end

    riscv_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk            (master_clk),
        .rst            (master_rst),
        .push_i         (push),
        .push_tag_i     (push_tag),
        .pop_i          (pop),
        .mark_discard_i (if_flush),
        .head_o         (head),
        .count_o        (outstanding),
        .full_o         (fifo_full),
        .empty_o        (fifo_empty)
    );

    // A fetch response arriving in the flush cycle is dropped as well.
    assign if_rsp_valid = pop & (head.src == SRC_IF) & !head.discard & !if_flush;
    assign dm_rsp_valid = pop & (head.src == SRC_DM);
    assign if_rsp_data  = mem_rsp_data;
    assign dm_rsp_data  = mem_rsp_data;
    assign arb_err      = arb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_mem_arbiter
// Description : Directed self-checking bench for riscv_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_arbiter;

    logic        master_clk;
    logic        master_rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_flush;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic [31:0] dm_req_addr;
    logic        dm_req_we;
    logic [31:0] dm_req_wdata;
    logic [3:0]  dm_req_be;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_we;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [2:0]  outstanding;
    logic        arb_err;

    int n_checks = 0;
    int n_errors = 0;

    riscv_mem_arbiter #(
        .WIDTH           (32),
        .MAX_OUTSTANDING (4),
        .STARVE_LIMIT    (8)
    ) dut (
        .master_clk    (master_clk),
        .master_rst    (master_rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_req_addr   (if_req_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .if_flush      (if_flush),
        .dm_req_valid  (dm_req_valid),
        .dm_req_ready  (dm_req_ready),
        .dm_req_addr   (dm_req_addr),
        .dm_req_we     (dm_req_we),
        .dm_req_wdata  (dm_req_wdata),
        .dm_req_be     (dm_req_be),
        .dm_rsp_valid  (dm_rsp_valid),
        .dm_rsp_data   (dm_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_we    (mem_req_we),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_be    (mem_req_be),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .outstanding   (outstanding),
        .arb_err       (arb_err)
    );

    initial master_clk = 1'b0;
    always #5 master_clk = ~master_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge master_clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_valid  = 1'b0;
        if_req_addr   = '0;
        if_flush      = 1'b0;
        dm_req_valid  = 1'b0;
        dm_req_addr   = '0;
        dm_req_we     = 1'b0;
        dm_req_wdata  = '0;
        dm_req_be     = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
    endtask

    task automatic do_reset();
        cyc();
        master_rst = 1'b1;
        idle_inputs();
        cyc();
        master_rst = 1'b0;
    endtask

    task automatic issue_if(input logic [31:0] addr);
        cyc();
        if_req_valid = 1'b1;
        if_req_addr  = addr;
        #1;
        chk("issue_if_ready", 64'(if_req_ready), 64'd1);
    endtask

    initial begin
        master_rst = 1'b1;
        idle_inputs();
        repeat (2) cyc();
        master_rst = 1'b0;
        #1;
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err", 64'(arb_err), 64'd0);
        chk("rst_memvalid", 64'(mem_req_valid), 64'd0);

        // Both requesters always valid, memory answers one cycle after accept.
        for (int c = 0; c < 18; c++) begin
            cyc();
            if_req_valid  = 1'b1;
            if_req_addr   = 32'h1000;
            dm_req_valid  = 1'b1;
            dm_req_addr   = 32'h2000;
            mem_rsp_valid = (c > 0);
            mem_rsp_data  = 32'(c);
            #1;
            chk("starve_if_ready", 64'(if_req_ready), 64'((c == 8) || (c == 17)));
            chk("starve_dm_ready", 64'(dm_req_ready), 64'(!((c == 8) || (c == 17))));
            if (c > 0) begin
                chk("starve_if_rsp", 64'(if_rsp_valid), 64'(c == 9));
                chk("starve_dm_rsp", 64'(dm_rsp_valid), 64'(c != 9));
            end
        end
        do_reset();

        // Fill to MAX_OUTSTANDING with no responses.
        for (int k = 0; k < 4; k++) issue_if(32'h40 + 32'(4 * k));
        cyc();
        #1;
        chk("full_count", 64'(outstanding), 64'd4);
        chk("full_if_ready", 64'(if_req_ready), 64'd0);
        chk("full_memvalid", 64'(mem_req_valid), 64'd0);
        cyc();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hA5;
        #1;
        chk("full_rsp_valid", 64'(if_rsp_valid), 64'd1);
        chk("full_rsp_data", 64'(if_rsp_data), 64'hA5);
        chk("full_nobypass", 64'(if_req_ready), 64'd0);
        cyc();
        mem_rsp_valid = 1'b0;
        #1;
        chk("pop_count", 64'(outstanding), 64'd3);
        chk("pop_if_ready", 64'(if_req_ready), 64'd1);
        cyc();
        if_req_valid = 1'b0;
        #1;
        chk("refill_count", 64'(outstanding), 64'd4);
        do_reset();

        // Interleaved IF / DM write / IF, then in-order responses.
        cyc();
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0;
        #1;
        chk("il0_addr", 64'(mem_req_addr), 64'h0);
        chk("il0_we", 64'(mem_req_we), 64'd0);
        chk("il0_be", 64'(mem_req_be), 64'hF);
        cyc();
        if_req_valid = 1'b0;
        dm_req_valid = 1'b1;
        dm_req_addr  = 32'h100;
        dm_req_we    = 1'b1;
        dm_req_wdata = 32'hDEAD;
        dm_req_be    = 4'h3;
        #1;
        chk("il1_dm_ready", 64'(dm_req_ready), 64'd1);
        chk("il1_addr", 64'(mem_req_addr), 64'h100);
        chk("il1_we", 64'(mem_req_we), 64'd1);
        chk("il1_wdata", 64'(mem_req_wdata), 64'hDEAD);
        chk("il1_be", 64'(mem_req_be), 64'h3);
        cyc();
        dm_req_valid = 1'b0;
        dm_req_we    = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = 32'h4;
        #1;
        chk("il2_addr", 64'(mem_req_addr), 64'h4);
        chk("il2_count", 64'(outstanding), 64'd2);
        cyc();
        if_req_valid  = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hD0;
        #1;
        chk("d0_if", 64'(if_rsp_valid), 64'd1);
        chk("d0_dm", 64'(dm_rsp_valid), 64'd0);
        chk("d0_data", 64'(if_rsp_data), 64'hD0);
        cyc();
        mem_rsp_data = 32'hD1;
        #1;
        chk("d1_if", 64'(if_rsp_valid), 64'd0);
        chk("d1_dm", 64'(dm_rsp_valid), 64'd1);
        chk("d1_data", 64'(dm_rsp_data), 64'hD1);
        cyc();
        mem_rsp_data = 32'hD2;
        #1;
        chk("d2_if", 64'(if_rsp_valid), 64'd1);
        chk("d2_dm", 64'(dm_rsp_valid), 64'd0);
        cyc();
        mem_rsp_valid = 1'b0;
        #1;
        chk("il_drained", 64'(outstanding), 64'd0);
        do_reset();

        // Flush with three fetches in flight; first response lands in the flush cycle.
        for (int k = 0; k < 3; k++) issue_if(32'h200 + 32'(4 * k));
        cyc();
        if_req_addr   = 32'h20C;
        if_flush      = 1'b1;
        mem_rsp_valid = 1'b1;
        #1;
        chk("fl_if_ready", 64'(if_req_ready), 64'd0);
        chk("fl_memvalid", 64'(mem_req_valid), 64'd0);
        chk("fl_rsp0", 64'(if_rsp_valid), 64'd0);
        cyc();
        if_flush     = 1'b0;
        if_req_valid = 1'b0;
        #1;
        chk("fl_rsp1", 64'(if_rsp_valid), 64'd0);
        chk("fl_rsp1_dm", 64'(dm_rsp_valid), 64'd0);
        cyc();
        #1;
        chk("fl_rsp2", 64'(if_rsp_valid), 64'd0);
        cyc();
        mem_rsp_valid = 1'b0;
        if_req_valid  = 1'b1;
        if_req_addr   = 32'h300;
        #1;
        chk("fl_empty", 64'(outstanding), 64'd0);
        chk("fl_new_ready", 64'(if_req_ready), 64'd1);
        cyc();
        if_req_valid  = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h77;
        #1;
        chk("fl_new_rsp", 64'(if_rsp_valid), 64'd1);
        chk("fl_new_data", 64'(if_rsp_data), 64'h77);
        cyc();
        mem_rsp_valid = 1'b0;
        #1;
        chk("fl_no_err", 64'(arb_err), 64'd0);
        do_reset();

        // Response with empty FIFO is a protocol error.
        cyc();
        mem_rsp_valid = 1'b1;
        #1;
        chk("err_no_if", 64'(if_rsp_valid), 64'd0);
        chk("err_no_dm", 64'(dm_rsp_valid), 64'd0);
        cyc();
        mem_rsp_valid = 1'b0;
        #1;
        chk("err_set", 64'(arb_err), 64'd1);
        chk("err_count", 64'(outstanding), 64'd0);
        repeat (3) cyc();
        chk("err_sticky", 64'(arb_err), 64'd1);
        do_reset();
        #1;
        chk("err_cleared", 64'(arb_err), 64'd0);

        // Reset with two fetches outstanding.
        for (int k = 0; k < 2; k++) issue_if(32'h400 + 32'(4 * k));
        cyc();
        master_rst = 1'b1;
        idle_inputs();
        #1;
        chk("mr_pre_count", 64'(outstanding), 64'd2);
        cyc();
        master_rst = 1'b0;
        #1;
        chk("mr_count", 64'(outstanding), 64'd0);
        chk("mr_memvalid", 64'(mem_req_valid), 64'd0);
        chk("mr_if_ready", 64'(if_req_ready), 64'd0);
        chk("mr_dm_ready", 64'(dm_req_ready), 64'd0);
        chk("mr_if_rsp", 64'(if_rsp_valid), 64'd0);
        chk("mr_dm_rsp", 64'(dm_rsp_valid), 64'd0);
        chk("mr_err", 64'(arb_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
